// File: rtl/regfile_pkg.sv
// Shared types and default sizing for the multi-port register file.
package regfile_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } rf_state_t;

  localparam int RF_DATA_W = 32;
  localparam int RF_ADDR_W = 5;
  localparam int RF_NUM_RD = 2;

endpackage

// File: rtl/regfile_rdport.sv
// One registered read port: zero-register, write-first bypass and array mux.
module regfile_rdport
  import regfile_pkg::*;
#(
  parameter int DATA_W   = RF_DATA_W,
  parameter int ADDR_W   = RF_ADDR_W,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  input  logic [ADDR_W-1:0] raddr,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] rdata_q, rdata_d;

  // wr_en already excludes writes to the zero register, so bypass never leaks into r0.
  always_comb begin
    rdata_d = '0;
    if (run) begin
      if ((ZERO_REG != 0) && (raddr == '0)) begin
        rdata_d = '0;
      end else if (wr_en && (waddr == raddr)) begin
        rdata_d = wdata;
      end else begin
        rdata_d = mem_rdata;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/regfile_mp.sv
// Parametrised register file: one write port, NUM_RD registered read ports,
// and a clear sequencer that zeroes every entry after reset.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W   = RF_DATA_W,
  parameter int ADDR_W   = RF_ADDR_W,
  parameter int NUM_RD   = RF_NUM_RD,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     we,
  input  logic [ADDR_W-1:0]        waddr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic [NUM_RD*ADDR_W-1:0] raddr,
  output logic [NUM_RD*DATA_W-1:0] rdata,
  output logic                     init_done
);

  localparam int                DEPTH     = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  rf_state_t         state_q, state_d;
  logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
  logic              init_done_q, init_done_d;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              wr_legal;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  // The array has a single write port shared by the clear sweep and the user write.
  always_comb begin
    state_d     = state_q;
    clr_ptr_d   = clr_ptr_q;
    init_done_d = init_done_q;
    wr_legal    = 1'b0;
    mem_we      = 1'b0;
    mem_waddr   = waddr;
    mem_wdata   = wdata;
    case (state_q)
      CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = clr_ptr_q;
        mem_wdata = '0;
        clr_ptr_d = clr_ptr_q + ADDR_W'(1);
        if (clr_ptr_q == LAST_ADDR) begin
          state_d     = RUN;
          init_done_d = 1'b1;
          clr_ptr_d   = '0;
        end
      end
      RUN: begin
        wr_legal = we && !((ZERO_REG != 0) && (waddr == '0));
        mem_we   = wr_legal;
      end
      default: begin
        state_d = CLEAR;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= CLEAR;
      clr_ptr_q   <= '0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      clr_ptr_q   <= clr_ptr_d;
      init_done_q <= init_done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    regfile_rdport #(
      .DATA_W  (DATA_W),
      .ADDR_W  (ADDR_W),
      .ZERO_REG(ZERO_REG)
    ) u_rdport (
      .clk      (clk),
      .rst_n    (rst_n),
      .run      (state_q == RUN),
      .raddr    (raddr[k*ADDR_W +: ADDR_W]),
      .wr_en    (wr_legal),
      .waddr    (waddr),
      .wdata    (wdata),
      .mem_rdata(mem_q[raddr[k*ADDR_W +: ADDR_W]]),
      .rdata    (rdata[k*DATA_W +: DATA_W])
    );
  end

  assign init_done = init_done_q;

endmodule
